hub_slot_responder: RTL
=======================

Name: hub_slot_responder

Overview:
- Hub-side responder for the cog hub bus. Services the hub memory and hub-op requests issued by up to 8 cogs.
- Grants access round-robin, one slot per ena_bus strobe. Performs byte/word/long reads and writes to a synchronous hub RAM and executes the COGID and lock hub-ops.
- Returns a one-hot ack with the broadcast bus_q/bus_c result that each cog's ALU consumes.

Parameters:
- ADDR_W, 16, byte address width of the hub space; mem_a is ADDR_W-2 bits.

Ports:
- clk_cog  in  1  system clock, rising edge
- nres  in  1  reset, asynchronous assert, active-low
- ena_bus  in  1  slot strobe; slot advances and may issue only when high
- req_sel  in  8  per-cog request pending, bit k = cog k
- req_rd  in  8  per-cog: 1 = read, 0 = write (ignored for hub-op)
- req_sz  in  16  per-cog 2 bits {2k+1:2k}: 00 byte, 01 word, 10 long, 11 hub-op
- req_a  in  8*ADDR_W  per-cog byte address
- req_d  in  256  per-cog write data / hub-op operand
- slot  out  3  current slot number
- bus_ack  out  8  one-hot, one-cycle completion pulse
- bus_q  out  32  result data
- bus_c  out  1  result carry
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write
- mem_be  out  4  RAM byte enables
- mem_a  out  ADDR_W-2  RAM long address
- mem_d  out  32  RAM write data
- mem_q  in  32  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (nres low, async): slot=0; pipeline valid bits=0; bus_ack=0; bus_q=0; bus_c=0; all mem_* outputs=0; all 8 locks free and unallocated. In-flight requests are dropped with no ack.
- Slot counter: on each clk_cog edge with ena_bus=1, slot increments mod 8 (7->0 wraps). With ena_bus=0, slot holds and nothing issues.
- Issue, cycle N (ena_bus=1, slot=k, req_sel[k]=1): capture cog k's rd/sz/a/d into stage 1. If req_sel[k]=0 nothing issues and that cog's slot is lost.
- Stage 1, cycle N+1: mem_* outputs are registered.
  - Read: mem_en=1, mem_we=0, mem_a=a[ADDR_W-1:2].
  - Write: mem_en=1, mem_we=1.
    - Byte: mem_be=1<<a[1:0], mem_d=byte replicated x4.
    - Word: mem_be=a[1]?1100:0011, mem_d=halfword replicated x2, a[0] ignored.
    - Long: mem_be=1111, a[1:0] ignored.
  - Hub-op: mem_en=0. The lock/COGID result is computed and lock state is updated at the end of N+1.
- Stage 2, cycle N+2: mem_q is captured and formatted.
  - Byte read: zero-extended byte lane a[1:0].
  - Word read: zero-extended lane a[1].
  - Write: bus_q=0, bus_c=0.
- Cycle N+3: bus_ack[k]=1 for exactly one cycle; bus_q/bus_c are valid. Fixed issue-to-ack latency is 3 clk_cog cycles. Outside ack cycles, bus_q/bus_c hold their last value.
- Hub-op function is req_d[2:0]; lock id is req_d[5:3].
  - 1 COGID: bus_q=k, bus_c=0.
  - 4 LOCKNEW: allocates the lowest unallocated lock; bus_q=id, bus_c=0. If none are free: bus_q=0, bus_c=1, no change.
  - 5 LOCKRET: deallocates id and clears its state; bus_q=id, bus_c=0. Returning a free lock has no effect.
  - 6 LOCKSET: bus_c=previous state, state<=1; bus_q=id.
  - 7 LOCKCLR: bus_c=previous state, state<=0; bus_q=id.
  - 0, 2, 3: no effect, bus_q=0, bus_c=0, ack still issued.
- Handshake: a cog holds req_sel and operands stable until it sees its ack, then drops req_sel within 4 cycles. Only one slot issues per ena_bus, so lock updates are never concurrent.
- Up to 3 transactions may be in flight (ena_bus every cycle); all stages are independent.

Optional Feature:
- HUB_ROM_WP_EN defined: writes with a[ADDR_W-1]=1 (upper half, ROM) drive mem_en=0 and mem_we=0. They are still acked with bus_q=0, bus_c=1 to flag the rejected write.
- Undefined: every address is writable and write acks return bus_c=0.

Test Plan:
- Reset, then ena_bus=1 continuously -> slot sequence 0,1..7,0. No ack without req_sel.
- mem preloaded 0x11223344 at long 0x10. Cog 3: byte read a=0x0042 issued at slot 3 -> 3 cycles later bus_ack=0x08, bus_q=0x00000022. Word read a=0x0042 -> bus_q=0x00001122.
- Cog 0: byte write a=0x0005, d=0xAB -> mem_we=1, mem_be=0010, mem_a=1, mem_d=0xABABABAB. Ack with bus_q=0.
- Cogs 1 and 2 issue LOCKNEW -> ids 0 then 1. Cog 1 LOCKSET id0 -> c=0, repeated -> c=1. LOCKCLR id0 -> c=1. Nine LOCKNEWs total -> ninth returns c=1.
- Reset asserted during cycle N+2 of a read -> no ack, bus_q=0, locks free. First issue after release acks normally.
- With HUB_ROM_WP_EN: long write a=0x8000 -> mem_en stays 0, ack with bus_c=1. Without it -> mem_we=1, bus_c=0.

Source files
------------

// File: rtl/hub_slot_responder.sv
// rtl/hub_slot_responder.sv - round-robin cog hub slot responder with locks; optional HUB_ROM_WP_EN write-protects the upper half
module hub_slot_responder #(
    parameter int ADDR_W = 16
) (
    input  logic                clk_cog,
    input  logic                nres,
    input  logic                ena_bus,
    input  logic [7:0]          req_sel,
    input  logic [7:0]          req_rd,
    input  logic [15:0]         req_sz,
    input  logic [8*ADDR_W-1:0] req_a,
    input  logic [255:0]        req_d,
    output logic [2:0]          slot,
    output logic [7:0]          bus_ack,
    output logic [31:0]         bus_q,
    output logic                bus_c,
    output logic                mem_en,
    output logic                mem_we,
    output logic [3:0]          mem_be,
    output logic [ADDR_W-3:0]   mem_a,
    output logic [31:0]         mem_d,
    input  logic [31:0]         mem_q
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_HOP  = 2'd3;

    localparam logic [2:0] OP_COGID   = 3'd1;
    localparam logic [2:0] OP_LOCKNEW = 3'd4;
    localparam logic [2:0] OP_LOCKRET = 3'd5;
    localparam logic [2:0] OP_LOCKSET = 3'd6;
    localparam logic [2:0] OP_LOCKCLR = 3'd7;

    logic [1:0]        sz_arr [8];
    logic [ADDR_W-1:0] a_arr  [8];
    logic [31:0]       d_arr  [8];

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        assign sz_arr[g] = req_sz[2*g +: 2];
        assign a_arr[g]  = req_a[g*ADDR_W +: ADDR_W];
        assign d_arr[g]  = req_d[32*g +: 32];
    end

    logic              issue, i_rd, i_we, i_rej;
    logic [1:0]        i_sz;
    logic [ADDR_W-1:0] i_a;
    logic [31:0]       i_d, i_wd;
    logic [3:0]        i_be;

    always_comb begin
        issue = ena_bus && req_sel[slot];
        i_rd  = req_rd[slot];
        i_sz  = sz_arr[slot];
        i_a   = a_arr[slot];
        i_d   = d_arr[slot];
        i_we  = !i_rd && (i_sz != SZ_HOP);
`ifdef HUB_ROM_WP_EN
        i_rej = i_we && i_a[ADDR_W-1];
`else
        i_rej = 1'b0;
`endif
        case (i_sz)
            SZ_BYTE: begin
                i_be = 4'b0001 << i_a[1:0];
                i_wd = {4{i_d[7:0]}};
            end
            SZ_WORD: begin
                i_be = i_a[1] ? 4'b1100 : 4'b0011;
                i_wd = {2{i_d[15:0]}};
            end
            default: begin
                i_be = 4'b1111;
                i_wd = i_d;
            end
        endcase
    end

    // Stage 1: request captured and RAM strobes registered on the issue edge
    logic       s1_v, s1_rd, s1_rej;
    logic [2:0] s1_cog;
    logic [1:0] s1_sz, s1_a2;
    logic [5:0] s1_op;

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            slot   <= '0;
            s1_v   <= 1'b0;
            s1_rd  <= 1'b0;
            s1_rej <= 1'b0;
            s1_cog <= '0;
            s1_sz  <= '0;
            s1_a2  <= '0;
            s1_op  <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            mem_a  <= '0;
            mem_d  <= '0;
        end else begin
            if (ena_bus) begin
                slot <= slot + 3'd1;
            end
            s1_v   <= issue;
            mem_en <= issue && (i_sz != SZ_HOP) && !i_rej;
            mem_we <= issue && i_we && !i_rej;
            if (issue) begin
                s1_rd  <= i_rd;
                s1_rej <= i_rej;
                s1_cog <= slot;
                s1_sz  <= i_sz;
                s1_a2  <= i_a[1:0];
                s1_op  <= i_d[5:0];
                mem_a  <= i_a[ADDR_W-1:2];
                mem_be <= (i_sz == SZ_HOP) ? 4'b0000 : (i_rd ? 4'b1111 : i_be);
                mem_d  <= i_we ? i_wd : 32'd0;
            end
        end
    end

    logic [7:0]  lock_alloc, lock_state, lock_alloc_nxt, lock_state_nxt;
    logic [2:0]  lock_id, free_id;
    logic        free_ok, hop_c;
    logic [31:0] hop_q;

    always_comb begin
        lock_alloc_nxt = lock_alloc;
        lock_state_nxt = lock_state;
        lock_id        = s1_op[5:3];
        hop_q          = '0;
        hop_c          = 1'b0;
        free_id        = '0;
        free_ok        = 1'b0;
        // Descending scan so the lowest free lock wins
        for (int i = 7; i >= 0; i--) begin
            if (!lock_alloc[i]) begin
                free_id = 3'(i);
                free_ok = 1'b1;
            end
        end
        if (s1_v && s1_sz == SZ_HOP) begin
            case (s1_op[2:0])
                OP_COGID: hop_q = {29'd0, s1_cog};
                OP_LOCKNEW: begin
                    if (free_ok) begin
                        lock_alloc_nxt[free_id] = 1'b1;
                        hop_q = {29'd0, free_id};
                    end else begin
                        hop_c = 1'b1;
                    end
                end
                OP_LOCKRET: begin
                    hop_q = {29'd0, lock_id};
                    if (lock_alloc[lock_id]) begin
                        lock_alloc_nxt[lock_id] = 1'b0;
                        lock_state_nxt[lock_id] = 1'b0;
                    end
                end
                OP_LOCKSET: begin
                    hop_q = {29'd0, lock_id};
                    hop_c = lock_state[lock_id];
                    lock_state_nxt[lock_id] = 1'b1;
                end
                OP_LOCKCLR: begin
                    hop_q = {29'd0, lock_id};
                    hop_c = lock_state[lock_id];
                    lock_state_nxt[lock_id] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic        s2_v, s2_rdmem, s2_c;
    logic [2:0]  s2_cog;
    logic [1:0]  s2_sz, s2_a2;
    logic [31:0] s2_q;

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            lock_alloc <= '0;
            lock_state <= '0;
            s2_v       <= 1'b0;
            s2_rdmem   <= 1'b0;
            s2_c       <= 1'b0;
            s2_cog     <= '0;
            s2_sz      <= '0;
            s2_a2      <= '0;
            s2_q       <= '0;
        end else begin
            lock_alloc <= lock_alloc_nxt;
            lock_state <= lock_state_nxt;
            s2_v       <= s1_v;
            s2_rdmem   <= s1_rd && (s1_sz != SZ_HOP);
            s2_c       <= hop_c | s1_rej;
            s2_cog     <= s1_cog;
            s2_sz      <= s1_sz;
            s2_a2      <= s1_a2;
            s2_q       <= hop_q;
        end
    end

    logic [31:0] rd_q;
    logic [7:0]  rd_byte;

    always_comb begin
        case (s2_a2)
            2'd0:    rd_byte = mem_q[7:0];
            2'd1:    rd_byte = mem_q[15:8];
            2'd2:    rd_byte = mem_q[23:16];
            default: rd_byte = mem_q[31:24];
        endcase
        case (s2_sz)
            SZ_BYTE: rd_q = {24'd0, rd_byte};
            SZ_WORD: rd_q = s2_a2[1] ? {16'd0, mem_q[31:16]} : {16'd0, mem_q[15:0]};
            default: rd_q = mem_q;
        endcase
    end

    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            bus_ack <= '0;
            bus_q   <= '0;
            bus_c   <= 1'b0;
        end else begin
            bus_ack <= s2_v ? (8'd1 << s2_cog) : 8'd0;
            if (s2_v) begin
                bus_q <= s2_rdmem ? rd_q : s2_q;
                bus_c <= s2_rdmem ? 1'b0 : s2_c;
            end
        end
    end

endmodule
